// File: rtl/fnd_pkg.sv
// Shared glyph constants and helpers for the multiplexed seven-segment driver.
// Glyphs are stored active-low in {a,b,c,d,e,f,g} order.
package fnd_pkg;

  typedef logic [6:0] glyph_t;

  localparam int MAX_DIGITS = 8;

  localparam glyph_t GLYPH_0     = 7'b0000001;
  localparam glyph_t GLYPH_1     = 7'b1001111;
  localparam glyph_t GLYPH_2     = 7'b0010010;
  localparam glyph_t GLYPH_3     = 7'b0000110;
  localparam glyph_t GLYPH_4     = 7'b1001100;
  localparam glyph_t GLYPH_5     = 7'b0100100;
  localparam glyph_t GLYPH_6     = 7'b0100000;
  localparam glyph_t GLYPH_7     = 7'b0001111;
  localparam glyph_t GLYPH_8     = 7'b0000000;
  localparam glyph_t GLYPH_9     = 7'b0000100;
  localparam glyph_t GLYPH_A     = 7'b0001000;
  localparam glyph_t GLYPH_B     = 7'b1100000;
  localparam glyph_t GLYPH_C     = 7'b0110001;
  localparam glyph_t GLYPH_D     = 7'b1000010;
  localparam glyph_t GLYPH_E     = 7'b0110000;
  localparam glyph_t GLYPH_F     = 7'b0111000;
  localparam glyph_t GLYPH_BLANK = 7'b1111111;

  // Active-high one-hot of idx, restricted to the first n digit positions.
  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx, input int n);
    logic [MAX_DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if ((i < n) && (idx == 3'(i))) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fnd_scan_driver_if.sv
// Datapath-side and pin-side signals of the FND scan driver.
// master = the logic feeding values in; slave = the driver itself.
interface fnd_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    en;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output en, value, dp_in, load,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  en, value, dp_in, load,
    output seg, dp, an, frame_done
  );

endinterface

// File: rtl/fnd_glyph_rom.sv
// Nibble to active-low seven-segment glyph; hex_mode enables A..F,
// otherwise nibbles above 9 and any blanked digit read as all segments off.
module fnd_glyph_rom
  import fnd_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  input  logic       blank,
  output glyph_t     glyph
);

  always_comb begin
    glyph = GLYPH_BLANK;
    if (!blank) begin
      case (nibble)
        4'h0:    glyph = GLYPH_0;
        4'h1:    glyph = GLYPH_1;
        4'h2:    glyph = GLYPH_2;
        4'h3:    glyph = GLYPH_3;
        4'h4:    glyph = GLYPH_4;
        4'h5:    glyph = GLYPH_5;
        4'h6:    glyph = GLYPH_6;
        4'h7:    glyph = GLYPH_7;
        4'h8:    glyph = GLYPH_8;
        4'h9:    glyph = GLYPH_9;
        4'hA:    glyph = hex_mode ? GLYPH_A : GLYPH_BLANK;
        4'hB:    glyph = hex_mode ? GLYPH_B : GLYPH_BLANK;
        4'hC:    glyph = hex_mode ? GLYPH_C : GLYPH_BLANK;
        4'hD:    glyph = hex_mode ? GLYPH_D : GLYPH_BLANK;
        4'hE:    glyph = hex_mode ? GLYPH_E : GLYPH_BLANK;
        4'hF:    glyph = hex_mode ? GLYPH_F : GLYPH_BLANK;
        default: glyph = GLYPH_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/fnd_scan_driver.sv
// Time-multiplexed NUM_DIGITS-digit FND driver: prescaled digit scan, guard blanking,
// frame-aligned value latching, leading-zero suppression and selectable pin polarity.
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV      = 100000,
  parameter int GUARD         = 16,
  parameter int COMMON_ANODE  = 1,
  parameter int HEX_MODE      = 0,
  parameter int BLANK_LEADING = 1
) (
  input  logic             clk,
  input  logic             rst,
  fnd_scan_driver_if.slave bus
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic          OFF        = (COMMON_ANODE != 0);
  localparam logic          HEX_ON     = (HEX_MODE != 0);
  localparam logic          BLANK_ON   = (BLANK_LEADING != 0);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic                  pend_q, pend_d;
  logic [VW-1:0]         pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  logic                  slot_end;
  logic                  wrap;
  logic                  nz_above;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic [3:0]            cur_nibble;
  logic                  cur_blank;
  logic                  cur_dp;
  logic [NUM_DIGITS-1:0] an_hot;
  glyph_t                glyph;

  // Wrap is detected by compare so any digit count and divider are legal.
  always_comb begin
    slot_end = bus.en && (presc_q == PRESC_LAST);
    wrap     = slot_end && (idx_q == IDX_LAST);
    presc_d  = presc_q;
    idx_d    = idx_q;
    if (bus.en) begin
      presc_d = slot_end ? '0 : presc_q + PW'(1);
    end
    if (slot_end) begin
      idx_d = wrap ? '0 : idx_q + IW'(1);
    end
  end

  // Shadow only changes on the frame wrap, so one frame never mixes old and new data.
  always_comb begin
    pend_d       = pend_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    if (bus.load) begin
      pend_d     = 1'b1;
      pend_val_d = bus.value;
      pend_dp_d  = bus.dp_in;
    end
    if (wrap) begin
      if (bus.load) begin
        shadow_val_d = bus.value;
        shadow_dp_d  = bus.dp_in;
      end else if (pend_q) begin
        shadow_val_d = pend_val_q;
        shadow_dp_d  = pend_dp_q;
      end
      pend_d = 1'b0;
    end
  end

  // Walk from the top digit down; a digit is leading-blank until a nonzero nibble is seen.
  always_comb begin
    nz_above   = 1'b0;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz_above      = nz_above | (shadow_val_q[4*i +: 4] != 4'h0);
      blank_mask[i] = BLANK_ON && (i > 0) && !nz_above;
    end
    cur_nibble = 4'h0;
    cur_blank  = 1'b0;
    cur_dp     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nibble = shadow_val_q[4*i +: 4];
        cur_blank  = blank_mask[i];
        cur_dp     = shadow_dp_q[i];
      end
    end
  end

  fnd_glyph_rom u_glyph_rom (
    .nibble   (cur_nibble),
    .hex_mode (HEX_ON),
    .blank    (cur_blank),
    .glyph    (glyph)
  );

  // Everything below is active-high until the single polarity flip at the output register.
  always_comb begin
    an_hot = '0;
    if (bus.en && (presc_q >= GUARD_END)) begin
      an_hot = NUM_DIGITS'(onehot(3'(idx_q), NUM_DIGITS));
    end
    seg_d        = OFF ? glyph : ~glyph;
    dp_d         = OFF ? ~cur_dp : cur_dp;
    an_d         = OFF ? ~an_hot : an_hot;
    frame_done_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      pend_q       <= 1'b0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      seg_q        <= {7{OFF}};
      dp_q         <= OFF;
      an_q         <= {NUM_DIGITS{OFF}};
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      pend_q       <= pend_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule
